// File: rtl/mem_access_unit_pkg.sv
// Shared bus widths, FSM encoding, byte-lane select codes and RAM request payload
// for the data-memory access unit.
package mem_access_unit_pkg;

    // Bus widths
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;

    // Lane widths used by store replication and load extraction
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mau_state_e;

    // Byte-lane enable codes (little-endian lane 0 = bits [7:0])
    localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE0 = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE1 = 4'b0010;
    localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE2 = 4'b0100;
    localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE3 = 4'b1000;
    localparam logic [MEM_SEL_BUS-1:0] SEL_HALF0 = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] SEL_HALF1 = 4'b1100;
    localparam logic [MEM_SEL_BUS-1:0] SEL_WORD  = 4'b1111;

    // Request presented to the data RAM
    typedef struct packed {
        logic                   en;
        logic [MEM_SEL_BUS-1:0] we;
        logic [ADDR_BUS-1:0]    addr;
        logic [DATA_BUS-1:0]    wdata;
    } ram_req_t;

    // Copy right-aligned store data into every lane of its access size so the
    // strobes alone decide which bytes land in memory.
    function automatic logic [DATA_BUS-1:0] replicate_store(
        input logic [MEM_SEL_BUS-1:0] sel,
        input logic [DATA_BUS-1:0]    data
    );
        logic [DATA_BUS-1:0] lanes;
        case (sel)
            SEL_BYTE0, SEL_BYTE1, SEL_BYTE2, SEL_BYTE3: lanes = {4{data[BYTE_W-1:0]}};
            SEL_HALF0, SEL_HALF1:                       lanes = {2{data[HALF_W-1:0]}};
            default:                                    lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Combinational load formatter: picks the lanes named by mem_sel out of a RAM
// word and sign- or zero-extends them to a full register. Unknown selects give 0.
module mem_load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_BUS-1:0]    word_i,
    input  logic [MEM_SEL_BUS-1:0] mem_sel_i,
    input  logic                   sign_i,
    output logic [DATA_BUS-1:0]    data_o
);

    logic [BYTE_W-1:0] byte_c;
    logic [HALF_W-1:0] half_c;

    // Lane extraction: route the addressed byte/half down to bit 0
    always_comb begin
        byte_c = word_i[BYTE_W-1:0];
        half_c = word_i[HALF_W-1:0];
        case (mem_sel_i)
            SEL_BYTE1: byte_c = word_i[2*BYTE_W-1:BYTE_W];
            SEL_BYTE2: byte_c = word_i[3*BYTE_W-1:2*BYTE_W];
            SEL_BYTE3: byte_c = word_i[4*BYTE_W-1:3*BYTE_W];
            SEL_HALF1: half_c = word_i[2*HALF_W-1:HALF_W];
            default: begin
                byte_c = word_i[BYTE_W-1:0];
                half_c = word_i[HALF_W-1:0];
            end
        endcase
    end

    // Extension: replicate the lane MSB only for signed loads; illegal selects read as 0
    always_comb begin
        data_o = '0;
        case (mem_sel_i)
            SEL_BYTE0, SEL_BYTE1, SEL_BYTE2, SEL_BYTE3:
                data_o = {{(DATA_BUS-BYTE_W){sign_i & byte_c[BYTE_W-1]}}, byte_c};
            SEL_HALF0, SEL_HALF1:
                data_o = {{(DATA_BUS-HALF_W){sign_i & half_c[HALF_W-1]}}, half_c};
            SEL_WORD:
                data_o = word_i;
            default:
                data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Sequences one RAM access per instruction
// (IDLE -> [WAIT...] -> DONE), stalls the pipeline until the data is captured,
// and hands formatted load data or the ALU result to MEM/WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_current_stage,
    input  logic                   mem_read_flag,
    input  logic                   mem_write_flag,
    input  logic                   mem_sign_flag,
    input  logic [MEM_SEL_BUS-1:0] mem_sel,
    input  logic [DATA_BUS-1:0]    mem_write_data,
    input  logic [DATA_BUS-1:0]    result_in,
    input  logic                   reg_write_en_in,
    input  logic                   ram_ready,
    input  logic [DATA_BUS-1:0]    ram_read_data,
    output logic                   ram_en,
    output logic [MEM_SEL_BUS-1:0] ram_write_en,
    output logic [ADDR_BUS-1:0]    ram_addr,
    output logic [DATA_BUS-1:0]    ram_write_data,
    output logic [DATA_BUS-1:0]    result_out,
    output logic                   reg_write_en_out,
    output logic                   stall_request
);

    mau_state_e          state_q;
    mau_state_e          state_d;
    logic [DATA_BUS-1:0] load_q;
    logic [DATA_BUS-1:0] load_d;
    logic [DATA_BUS-1:0] fmt_data;
    logic                access_c;
    logic                issue_c;
    logic                capture_c;
    logic                stall_c;
    ram_req_t            req_c;

    assign access_c = mem_read_flag | mem_write_flag;

    // Load data is formatted on the way into the register so DONE just replays it
    mem_load_formatter u_load_formatter (
        .word_i    (ram_read_data),
        .mem_sel_i (mem_sel),
        .sign_i    (mem_sign_flag),
        .data_o    (fmt_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load register: cleared by reset, written only when the RAM answers a live request
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= '0;
        end else begin
            load_q <= load_d;
        end
    end

    // Next state and load capture; ram_ready is only honoured while a request is out
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        capture_c = issue_c & ram_ready;
        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    state_d = ram_ready ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ram_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall_current_stage) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture_c) begin
            load_d = fmt_data;
        end
    end

    // Outputs: request/stall from state, everything request-side forced low in reset
    always_comb begin
        issue_c          = 1'b0;
        stall_c          = 1'b0;
        req_c            = '0;
        result_out       = result_in;
        reg_write_en_out = reg_write_en_in;
        case (state_q)
            ST_IDLE: begin
                issue_c = access_c;
                stall_c = access_c;
            end
            ST_WAIT: begin
                issue_c = 1'b1;
                stall_c = access_c;
            end
            default: begin
                issue_c = 1'b0;
                stall_c = 1'b0;
            end
        endcase
        if (rst) begin
            stall_c = 1'b0;
        end else begin
            req_c.en    = issue_c;
            req_c.we    = (issue_c && mem_write_flag) ? mem_sel : '0;
            req_c.addr  = {result_in[ADDR_BUS-1:2], 2'b00};
            req_c.wdata = replicate_store(mem_sel, mem_write_data);
        end
        if ((state_q == ST_DONE) && mem_read_flag) begin
            result_out = load_q;
        end
        reg_write_en_out = reg_write_en_in & ~stall_c;
    end

    assign ram_en         = req_c.en;
    assign ram_write_en   = req_c.we;
    assign ram_addr       = req_c.addr;
    assign ram_write_data = req_c.wdata;
    assign stall_request  = stall_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// DONE-hold sequences, then random transactions against a lane-arithmetic model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        stall_current_stage;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] result_in;
    logic        reg_write_en_in;
    logic        ram_ready;
    logic [31:0] ram_read_data;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic        stall_request;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        sgn;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          hold;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
    } vec_t;

    vec_t       tbl[13];
    logic [3:0] legal_sel[7];
    logic [3:0] illegal_sel[7];

    mem_access_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall_current_stage),
        .mem_read_flag       (mem_read_flag),
        .mem_write_flag      (mem_write_flag),
        .mem_sign_flag       (mem_sign_flag),
        .mem_sel             (mem_sel),
        .mem_write_data      (mem_write_data),
        .result_in           (result_in),
        .reg_write_en_in     (reg_write_en_in),
        .ram_ready           (ram_ready),
        .ram_read_data       (ram_read_data),
        .ram_en              (ram_en),
        .ram_write_en        (ram_write_en),
        .ram_addr            (ram_addr),
        .ram_write_data      (ram_write_data),
        .result_out          (result_out),
        .reg_write_en_out    (reg_write_en_out),
        .stall_request       (stall_request)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic sgn,
                                input logic [3:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int waits, input int hold, input logic [3:0] exp_we,
                                input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_result);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sgn = sgn; v.sel = sel; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.waits = waits; v.hold = hold;
        v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
        v.exp_result = exp_result;
        return v;
    endfunction

    // Reference load: lane group = contiguous, size-aligned run of 1, 2 or 4 bytes
    function automatic logic [31:0] ref_load(input logic [3:0] sel, input logic sgn,
                                             input logic [31:0] w);
        int n;
        int off;
        longint unsigned mask;
        longint unsigned val;
        if (sel == 4'b0000) return 32'h0;
        n = $countones(sel);
        off = 0;
        while (!sel[off]) off++;
        if (!(n == 1 || n == 2 || n == 4)) return 32'h0;
        if ((off % n) != 0) return 32'h0;
        if ((int'(sel) >> off) != ((1 << n) - 1)) return 32'h0;
        mask = (64'd1 << (8 * n)) - 64'd1;
        val = ({32'd0, w} >> (8 * off)) & mask;
        if (sgn && (((val >> (8 * n - 1)) & 64'd1) != 64'd0)) val = val | ~mask;
        return 32'(val);
    endfunction

    // Reference store data: right-aligned value copied into every lane of its size
    function automatic logic [31:0] ref_store(input logic [3:0] sel, input logic [31:0] d);
        case ($countones(sel))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // One complete access: request cycles (stall high), then DONE (optionally held)
    task automatic do_txn(input vec_t v, input int id);
        @(posedge clk); #1;
        mem_read_flag       = v.rd;
        mem_write_flag      = v.wr;
        mem_sign_flag       = v.sgn;
        mem_sel             = v.sel;
        result_in           = v.addr;
        mem_write_data      = v.wdata;
        reg_write_en_in     = 1'b1;
        stall_current_stage = 1'b0;
        for (int c = 0; c <= v.waits; c++) begin
            ram_ready     = (c == v.waits);
            ram_read_data = (c == v.waits) ? v.rdata : $urandom;
            @(negedge clk);
            chk1($sformatf("v%0d c%0d stall_request", id, c), stall_request, 1'b1);
            chk1($sformatf("v%0d c%0d ram_en", id, c), ram_en, 1'b1);
            chk($sformatf("v%0d c%0d ram_write_en", id, c), 32'(ram_write_en), 32'(v.exp_we));
            chk($sformatf("v%0d c%0d ram_addr", id, c), ram_addr, v.exp_addr);
            chk($sformatf("v%0d c%0d ram_write_data", id, c), ram_write_data, v.exp_wdata);
            chk1($sformatf("v%0d c%0d reg_write_en_out", id, c), reg_write_en_out, 1'b0);
            @(posedge clk); #1;
        end
        for (int h = 0; h <= v.hold; h++) begin
            stall_current_stage = (h < v.hold);
            ram_ready           = 1'($urandom_range(0, 1));
            ram_read_data       = $urandom;
            @(negedge clk);
            chk1($sformatf("v%0d done%0d stall_request", id, h), stall_request, 1'b0);
            chk1($sformatf("v%0d done%0d ram_en", id, h), ram_en, 1'b0);
            chk($sformatf("v%0d done%0d result_out", id, h), result_out, v.exp_result);
            chk1($sformatf("v%0d done%0d reg_write_en_out", id, h), reg_write_en_out, 1'b1);
            if (h < v.hold) begin
                @(posedge clk); #1;
            end
        end
        stall_current_stage = 1'b0;
        ram_ready           = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic is_load;

        n_checks = 0;
        n_fail   = 0;

        legal_sel   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        illegal_sel = '{4'b0000, 4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1110};

        //             rd wr sg sel      addr          wdata         rdata         wt hd we       exp_addr      exp_wdata     exp_result
        tbl[0]  = mk(1, 0, 0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF);
        tbl[1]  = mk(1, 0, 1, 4'b0100, 32'h0000_2000, 32'h0,        32'h0080_0000, 3, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'hFFFF_FF80);
        tbl[2]  = mk(1, 0, 0, 4'b0100, 32'h0000_2000, 32'h0,        32'h0080_0000, 3, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'h0000_0080);
        tbl[3]  = mk(0, 1, 0, 4'b1100, 32'h0000_0206, 32'h0000_ABCD, 32'h0,        1, 0, 4'b1100, 32'h0000_0204, 32'hABCD_ABCD, 32'h0000_0206);
        tbl[4]  = mk(0, 1, 0, 4'b0001, 32'h0000_1003, 32'h1234_56A5, 32'h0,        0, 0, 4'b0001, 32'h0000_1000, 32'hA5A5_A5A5, 32'h0000_1003);
        tbl[5]  = mk(0, 1, 0, 4'b1111, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        2, 0, 4'b1111, 32'h8000_0008, 32'hCAFE_F00D, 32'h8000_0008);
        tbl[6]  = mk(1, 0, 1, 4'b0011, 32'h0000_0010, 32'h0,        32'h1234_8001, 0, 0, 4'b0000, 32'h0000_0010, 32'h0,        32'hFFFF_8001);
        tbl[7]  = mk(1, 0, 0, 4'b1100, 32'h0000_0012, 32'h0,        32'h9ABC_0000, 1, 0, 4'b0000, 32'h0000_0010, 32'h0,        32'h0000_9ABC);
        tbl[8]  = mk(1, 0, 1, 4'b1000, 32'h0000_0033, 32'h0,        32'h7F00_0000, 0, 0, 4'b0000, 32'h0000_0030, 32'h0,        32'h0000_007F);
        tbl[9]  = mk(1, 0, 1, 4'b0010, 32'h0000_0005, 32'h0,        32'h0000_FE00, 2, 0, 4'b0000, 32'h0000_0004, 32'h0,        32'hFFFF_FFFE);
        tbl[10] = mk(1, 0, 1, 4'b0101, 32'h0000_0008, 32'h0,        32'hFFFF_FFFF, 0, 0, 4'b0000, 32'h0000_0008, 32'h0,        32'h0000_0000);
        tbl[11] = mk(1, 1, 0, 4'b0011, 32'h0000_000C, 32'h0000_5A5A, 32'h0000_1234, 1, 0, 4'b0011, 32'h0000_000C, 32'h5A5A_5A5A, 32'h0000_1234);
        tbl[12] = mk(1, 0, 0, 4'b1111, 32'h0000_0400, 32'h0,        32'h1122_3344, 0, 2, 4'b0000, 32'h0000_0400, 32'h0,        32'h1122_3344);

        // Reset with an access presented: request side must stay quiet
        rst                 = 1'b1;
        stall_current_stage = 1'b0;
        mem_read_flag       = 1'b1;
        mem_write_flag      = 1'b1;
        mem_sign_flag       = 1'b0;
        mem_sel             = 4'b1111;
        mem_write_data      = 32'h5555_AAAA;
        result_in           = 32'h0000_1234;
        reg_write_en_in     = 1'b1;
        ram_ready           = 1'b1;
        ram_read_data       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst ram_en", ram_en, 1'b0);
        chk("rst ram_write_en", 32'(ram_write_en), 32'h0);
        chk1("rst stall_request", stall_request, 1'b0);

        @(posedge clk); #1;
        rst            = 1'b0;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        ram_ready      = 1'b0;
        @(negedge clk);
        chk1("post_rst ram_en", ram_en, 1'b0);
        chk("post_rst ram_write_en", 32'(ram_write_en), 32'h0);
        chk1("post_rst stall_request", stall_request, 1'b0);
        chk("post_rst result_out", result_out, 32'h0000_1234);

        // ram_ready with no request outstanding is ignored
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            ram_ready     = 1'b1;
            ram_read_data = $urandom;
            result_in     = 32'h0000_0777 + 32'(i);
            @(negedge clk);
            chk1($sformatf("idle_ready%0d ram_en", i), ram_en, 1'b0);
            chk1($sformatf("idle_ready%0d stall_request", i), stall_request, 1'b0);
            chk($sformatf("idle_ready%0d result_out", i), result_out, 32'h0000_0777 + 32'(i));
            chk1($sformatf("idle_ready%0d reg_write_en_out", i), reg_write_en_out, 1'b1);
        end
        ram_ready = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i], i);
        end

        // Reset while waiting on the RAM, then a clean restart
        @(posedge clk); #1;
        mem_read_flag  = 1'b1;
        mem_write_flag = 1'b0;
        mem_sel        = 4'b1111;
        result_in      = 32'h0000_0040;
        ram_ready      = 1'b0;
        @(negedge clk);
        chk1("rst_wait idle stall_request", stall_request, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rst_wait wait ram_en", ram_en, 1'b1);
        chk1("rst_wait wait stall_request", stall_request, 1'b1);
        @(posedge clk); #1;
        rst           = 1'b1;
        ram_ready     = 1'b1;
        ram_read_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk1("rst_wait during ram_en", ram_en, 1'b0);
        chk1("rst_wait during stall_request", stall_request, 1'b0);
        @(posedge clk); #1;
        rst           = 1'b0;
        mem_read_flag = 1'b0;
        ram_ready     = 1'b0;
        @(negedge clk);
        chk1("rst_wait after ram_en", ram_en, 1'b0);
        chk1("rst_wait after stall_request", stall_request, 1'b0);
        chk("rst_wait after ram_write_en", 32'(ram_write_en), 32'h0);
        chk("rst_wait after result_out", result_out, 32'h0000_0040);
        v = mk(1, 0, 1, 4'b0001, 32'h0000_0041, 32'h0, 32'h0000_0081, 1, 1,
               4'b0000, 32'h0000_0040, 32'h0, 32'hFFFF_FF81);
        do_txn(v, 50);

        // Random transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            is_load = 1'($urandom_range(0, 1));
            v.rd    = is_load;
            v.wr    = ~is_load;
            v.sgn   = 1'($urandom_range(0, 1));
            v.sel   = legal_sel[$urandom_range(0, 6)];
            if (is_load && ($urandom_range(0, 5) == 0)) v.sel = illegal_sel[$urandom_range(0, 6)];
            v.addr  = $urandom;
            v.wdata = is_load ? 32'h0 : $urandom;
            v.rdata = $urandom;
            v.waits = int'($urandom_range(0, 3));
            v.hold  = int'($urandom_range(0, 2));
            v.exp_we     = is_load ? 4'b0000 : v.sel;
            v.exp_addr   = v.addr & 32'hFFFF_FFFC;
            v.exp_wdata  = ref_store(v.sel, v.wdata);
            v.exp_result = is_load ? ref_load(v.sel, v.sgn, v.rdata) : v.addr;
            do_txn(v, 100 + i);
        end

        @(posedge clk); #1;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: none; all widths SHALL come from the shared bus header (`DATA_BUS` 32, `ADDR_BUS` 32, `MEM_SEL_BUS` 4).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall_current_stage  in  1  pipeline controller holds MEM-stage instruction.
REQ-005 mem_read_flag / mem_write_flag / mem_sign_flag  in  1 each  load, store, sign-extend-load.
REQ-006 mem_sel  in  4  byte-lane enables: 0001/0010/0100/1000 byte, 0011/1100 half, 1111 word.
REQ-007 mem_write_data  in  32  store data, right-aligned.
REQ-008 result_in  in  32  ALU result; byte address for loads/stores.
REQ-009 reg_write_en_in  in  1  writeback enable from EX/MEM.
REQ-010 ram_ready  in  1  data RAM completes the presented access this cycle.
REQ-011 ram_read_data  in  32  RAM word, valid when ram_ready=1.
REQ-012 ram_en  out  1  access request.
REQ-013 ram_write_en  out  4  byte write strobes.
REQ-014 ram_addr  out  32  word address, {result_in[31:2],2'b00}.
REQ-015 ram_write_data  out  32  lane-replicated store data.
REQ-016 result_out  out  32  to MEM/WB: formatted load data or result_in.
REQ-017 reg_write_en_out  out  1  to MEM/WB.
REQ-018 stall_request  out  1  to pipeline controller; MEM stage busy.

Function
REQ-019 FSM states: IDLE, WAIT, DONE.
REQ-020 access = mem_read_flag | mem_write_flag.
REQ-021 IDLE: if access, then ram_en=1; ram_ready=1 -> DONE with data captured; ram_ready=0 -> WAIT. If no access, stay in IDLE with ram_en=0.
REQ-022 WAIT: ram_en=1 and address/strobes/data held stable; ram_ready=1 -> DONE with data captured; otherwise stay in WAIT.
REQ-023 DONE: ram_en=0; stall_current_stage=1 -> stay in DONE with no reissue; otherwise -> IDLE.
REQ-024 stall_request = access & (state==IDLE | state==WAIT); stall_request=0 in DONE.
REQ-025 Minimum access latency: 2 cycles (request cycle plus DONE cycle); each wait cycle adds 1 cycle.
REQ-026 ram_write_en = mem_sel when mem_write_flag=1, else 4'b0000.
REQ-027 ram_write_data: {4{data[7:0]}} for byte, {2{data[15:0]}} for half, data for word.
REQ-028 Load formatting: extract the lane(s) selected by mem_sel from the captured word (little-endian). If mem_sign_flag=1, sign-extend; otherwise zero-extend.
REQ-029 result_out = formatted load register when state==DONE & mem_read_flag; otherwise result_in.
REQ-030 reg_write_en_out = reg_write_en_in & ~stall_request.
REQ-031 mem_read_flag & mem_write_flag both 1 is illegal; the write SHALL take precedence and strobes SHALL equal mem_sel.
REQ-032 ram_ready while state==DONE or while ram_en=0 SHALL be ignored.
REQ-033 An illegal mem_sel on a load SHALL return a zero result, with no X propagation.

Reset
REQ-034 rst=1 SHALL force IDLE and clear the load register to 0, including mid-access in WAIT; ram_en, ram_write_en and stall_request are 0 in the cycle after rst.
REQ-035 While rst=1, all request outputs SHALL be 0 regardless of inputs.

Structure
REQ-036 Bus widths SHALL live in the shared bus header; FSM state encodings and mem_sel codes SHALL live in a shared constants header.
REQ-037 Load lane extraction/extension SHALL be a combinational sub-module, mem_load_formatter; FSM and registers SHALL reside in mem_access_unit.

Verification
REQ-038 Word load, addr 0x100, RAM ready immediately, data 0xDEADBEEF -> stall 1 cycle, result_out=0xDEADBEEF in DONE.
REQ-039 Signed byte load, mem_sel=0100, data 0x00800000, ram_ready delayed 3 cycles -> stall 4 cycles, result_out=0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Half store, mem_sel=1100, data 0x0000ABCD -> ram_write_en=1100, ram_write_data=0xABCDABCD, ram_addr word-aligned.
REQ-041 rst asserted in WAIT -> next cycle ram_en=0, stall_request=0; a later access restarts cleanly.
REQ-042 DONE with stall_current_stage=1 for 2 cycles, ram_ready pulsed -> no reissue, result_out held, ram_en=0.
